// File: rtl/rv_pkg.sv
// Shared RISC-V datapath constants and the register-index type, reused by the
// decoder, register file and writeback stages.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0] reg_idx_t;

endpackage : rv_pkg

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set when an
// instruction with a destination issues and cleared when its writeback returns.
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic          rs1_en,
  input  logic          rs2_en,
  input  logic          rd_en,
  input  logic          alloc_en,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  output logic          src1_haz,
  output logic          src2_haz,
  output logic          dst_haz
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic            w_wb_rs1;
  logic            w_wb_rs2;
  logic            w_wb_rd;

  // NOTE: every always_comb output gets a full default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    w_busy_next = r_busy;
    if (wb_en && (wb_addr != '0)) w_busy_next[wb_addr] = 1'b0;
    // Applied after the clear so a same-cycle reallocation keeps the bit set.
    if (alloc_en && (rd != '0))   w_busy_next[rd]      = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  // A writeback landing this cycle resolves the hazard via the bypass path.
  assign w_wb_rs1 = wb_en & (wb_addr == rs1);
  assign w_wb_rs2 = wb_en & (wb_addr == rs2);
  assign w_wb_rd  = wb_en & (wb_addr == rd);

  assign src1_haz = rs1_en & (rs1 != '0) & r_busy[rs1] & ~w_wb_rs1;
  assign src2_haz = rs2_en & (rs2 != '0) & r_busy[rs2] & ~w_wb_rs2;
  assign dst_haz  = rd_en  & (rd  != '0) & r_busy[rd]  & ~w_wb_rd;

endmodule : reg_scoreboard

// File: rtl/reg_file_scoreboard.sv
// Architectural integer register file with write-through bypass and a busy-bit
// scoreboard that stalls issue on RAW/WAW hazards against in-flight writes.
module reg_file_scoreboard
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            rs1_en,
  input  logic            rs2_en,
  input  logic            rd_en,
  input  logic            issue_valid,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            stall,
  output logic            issue_fire,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_src1_haz;
  logic            w_src2_haz;
  logic            w_dst_haz;
  logic            w_alloc;

  // NOTE: the array is reset explicitly because architectural state must read
  // zero after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    if (rs1 == '0)                      rd1 = '0;
    else if (wb_en && (wb_addr == rs1)) rd1 = wb_data;
    else                                rd1 = r_regs[rs1];
  end

  always_comb begin
    if (rs2 == '0)                      rd2 = '0;
    else if (wb_en && (wb_addr == rs2)) rd2 = wb_data;
    else                                rd2 = r_regs[rs2];
  end

  assign stall      = issue_valid & (w_src1_haz | w_src2_haz | w_dst_haz);
  assign issue_fire = issue_valid & ~stall;
  assign w_alloc    = issue_fire & rd_en;

  reg_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .rs1_en   (rs1_en),
    .rs2_en   (rs2_en),
    .rd_en    (rd_en),
    .alloc_en (w_alloc),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .src1_haz (w_src1_haz),
    .src2_haz (w_src2_haz),
    .dst_haz  (w_dst_haz)
  );

endmodule : reg_file_scoreboard

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench: directed scenarios followed by randomized traffic, all
// checked against an array-based model of register contents and busy bits.
module tb_reg_file_scoreboard;
  import rv_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1, rs2, rd, wb_addr;
  logic            rs1_en, rs2_en, rd_en, issue_valid, wb_en;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rd1, rd2;
  logic            stall, issue_fire;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: architectural values and in-flight destinations.
  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_busy [NREG];

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .rs1_en      (rs1_en),
    .rs2_en      (rs2_en),
    .rd_en       (rd_en),
    .issue_valid (issue_valid),
    .rd1         (rd1),
    .rd2         (rd2),
    .stall       (stall),
    .issue_fire  (issue_fire),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_reg[idx];
  endfunction

  function automatic bit model_blocked(input bit en, input logic [AW-1:0] idx);
    // A register is blocked while a write is pending and not arriving right now.
    return en && idx != 0 && m_busy[idx] && !(wb_en && wb_addr == idx);
  endfunction

  // Checks the combinational outputs for the current inputs (unless in reset),
  // then clocks once and advances the model. Inputs change only after negedge.
  task automatic tick(input string tag);
    bit exp_stall, exp_fire;
    #1;
    exp_stall = issue_valid && (model_blocked(rs1_en, rs1) ||
                                model_blocked(rs2_en, rs2) ||
                                model_blocked(rd_en, rd));
    exp_fire  = issue_valid && !exp_stall;
    if (!reset) begin
      chk({tag, ".rd1"},   rd1, model_read(rs1));
      chk({tag, ".rd2"},   rd2, model_read(rs2));
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
      chk({tag, ".fire"},  {31'd0, issue_fire}, {31'd0, exp_fire});
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wb_en && wb_addr != 0) begin
        m_reg[wb_addr]  = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (exp_fire && rd_en && rd != 0) m_busy[rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; issue_valid = 0; rs1_en = 0; rs2_en = 0; rd_en = 0; wb_en = 0;
    rs1 = 0; rs2 = 0; rd = 0; wb_addr = 0; wb_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    idle();
    reset = 1;
    @(negedge clk);
    tick("reset0");
    tick("reset1");

    // Every index reads zero after reset; no stall with all reads enabled.
    idle();
    issue_valid = 1; rs1_en = 1; rs2_en = 1;
    for (int i = 0; i < NREG; i++) begin
      rs1 = AW'(i); rs2 = AW'(NREG - 1 - i);
      #1;
      chk("zero_rd1", rd1, '0);
      chk("zero_rd2", rd2, '0);
      chk("zero_stall", {31'd0, stall}, '0);
      tick("zero_scan");
    end

    // Write-through bypass, then the stored value.
    idle();
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rs1 = 5;
    #1 chk("bypass_rd1", rd1, 32'hDEADBEEF);
    tick("bypass");
    wb_en = 0;
    #1 chk("stored_rd1", rd1, 32'hDEADBEEF);
    tick("stored");

    // x0 ignores writes and allocation.
    idle();
    wb_en = 1; wb_addr = 0; wb_data = 32'h1234;
    issue_valid = 1; rd_en = 1; rd = 0; rs1 = 0;
    #1 chk("x0_bypass", rd1, '0);
    tick("x0_write");
    idle();
    issue_valid = 1; rs1_en = 1; rs1 = 0; rd_en = 1; rd = 0;
    #1 chk("x0_rd1", rd1, '0);
    chk("x0_nostall", {31'd0, stall}, '0);
    tick("x0_read");

    // RAW on x13: stall until writeback arrives, resolved in the wb cycle.
    idle();
    issue_valid = 1; rd_en = 1; rd = 13;
    #1 chk("raw_alloc_fire", {31'd0, issue_fire}, 32'd1);
    tick("raw_alloc");
    idle();
    issue_valid = 1; rs1_en = 1; rs1 = 13;
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", {31'd0, stall}, 32'd1);
      tick("raw_wait");
    end
    wb_en = 1; wb_addr = 13; wb_data = 32'hCAFEF00D;
    #1 chk("raw_wb_stall", {31'd0, stall}, '0);
    chk("raw_wb_rd1", rd1, 32'hCAFEF00D);
    chk("raw_wb_fire", {31'd0, issue_fire}, 32'd1);
    tick("raw_wb");

    // WAW on x7, then same-cycle writeback + reallocation keeps x7 busy.
    idle();
    issue_valid = 1; rd_en = 1; rd = 7;
    tick("waw_alloc");
    #1 chk("waw_stall", {31'd0, stall}, 32'd1);
    tick("waw_block");
    wb_en = 1; wb_addr = 7; wb_data = 32'h00000777;
    #1 chk("waw_realloc_fire", {31'd0, issue_fire}, 32'd1);
    tick("waw_realloc");
    idle();
    issue_valid = 1; rs1_en = 1; rs1 = 7;
    #1 chk("waw_still_busy", {31'd0, stall}, 32'd1);
    chk("waw_data", rd1, 32'h00000777);
    tick("waw_check");
    idle();
    wb_en = 1; wb_addr = 7; wb_data = 32'h7;
    tick("waw_clear");

    // Reset drops in-flight state and a simultaneous writeback.
    idle();
    issue_valid = 1; rd_en = 1; rd = 3;
    tick("rst_alloc");
    idle();
    reset = 1; wb_en = 1; wb_addr = 3; wb_data = 32'h55;
    issue_valid = 1; rd_en = 1; rd = 9;
    tick("rst_cycle");
    idle();
    issue_valid = 1; rs1_en = 1; rs1 = 3; rs2_en = 1; rs2 = 9; rd_en = 1; rd = 9;
    #1 chk("rst_rd1", rd1, '0);
    chk("rst_nostall", {31'd0, stall}, '0);
    tick("rst_after");

    // Randomized traffic over a narrow index range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      issue_valid = $urandom_range(0, 3) != 0;
      rs1_en      = $urandom_range(0, 1) == 1;
      rs2_en      = $urandom_range(0, 1) == 1;
      rd_en       = $urandom_range(0, 2) != 0;
      rs1         = AW'($urandom_range(0, 7));
      rs2         = AW'($urandom_range(0, 7));
      rd          = AW'($urandom_range(0, 7));
      wb_en       = $urandom_range(0, 1) == 1;
      wb_addr     = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_reg_file_scoreboard
